// File: rtl/aidc_lite_pkg.sv
// Shared constants and types for the AIDC-Lite packer/unpacker pair.
package aidc_lite_pkg;

  localparam int unsigned AIDC_WORD_W    = 64;
  localparam int unsigned AIDC_MAX_WORDS = 8;
  localparam int unsigned AIDC_PREFIX_W  = 2;
  localparam int unsigned AIDC_ADDR_W    = $clog2(AIDC_MAX_WORDS);

  typedef enum logic [AIDC_PREFIX_W-1:0] {
    PFX_COMPRESSED = 2'b00,
    PFX_RSVD1      = 2'b01,
    PFX_RSVD2      = 2'b10,
    PFX_RSVD3      = 2'b11
  } aidc_prefix_e;

  typedef struct packed {
    logic [AIDC_ADDR_W-1:0] addr;
    logic [AIDC_WORD_W-1:0] data;
  } aidc_beat_t;

endpackage

// File: rtl/aidc_lite_bit_aligner.sv
// Masks an MSB-aligned fragment to its length and shifts it right by the fill level.
module aidc_lite_bit_aligner
  import aidc_lite_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 66,
  parameter int unsigned SIZE_W    = 7,
  parameter int unsigned BUF_W     = 129,
  parameter int unsigned SH_W      = 8
) (
  input  logic [DATA_SIZE-1:0] data,
  input  logic [SIZE_W-1:0]    size,
  input  logic [SH_W-1:0]      shift,
  output logic [BUF_W-1:0]     placed
);

  localparam int unsigned PAD_W = BUF_W - DATA_SIZE;

  logic [DATA_SIZE-1:0] keep;

  always_comb begin
    keep   = ~({DATA_SIZE{1'b1}} >> size);
    placed = {data & keep, {PAD_W{1'b0}}} >> shift;
  end

endmodule

// File: rtl/aidc_lite_code_packer.sv
// Packs variable-length code fragments into prefixed WORD_W-bit words with
// valid/ready output, overflow suppression and per-block length reporting.
module aidc_lite_code_packer
  import aidc_lite_pkg::*;
#(
  parameter int unsigned          PREFIX_W  = AIDC_PREFIX_W,
  parameter logic [PREFIX_W-1:0]  PREFIX    = PREFIX_W'(PFX_COMPRESSED),
  parameter int unsigned          DATA_SIZE = 66,
  parameter int unsigned          SIZE_W    = 7,
  parameter int unsigned          WORD_W    = AIDC_WORD_W,
  parameter int unsigned          MAX_WORDS = AIDC_MAX_WORDS,
  parameter int unsigned          ADDR_W    = $clog2(MAX_WORDS),
  parameter int unsigned          CNT_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 sop_i,
  input  logic                 eop_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic [SIZE_W-1:0]    size_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [WORD_W-1:0]    data_o,
  output logic [CNT_W-1:0]     blk_bits_o,
  output logic                 done_o,
  output logic                 fail_o
);

  localparam int unsigned BUF_W = WORD_W + DATA_SIZE - 1;
  localparam int unsigned RC_W  = $clog2(BUF_W + 1);
  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);
  localparam int unsigned LIMIT = MAX_WORDS * WORD_W;
  localparam logic [BUF_W-1:0] PREFIX_BUF = {PREFIX, {(BUF_W-PREFIX_W){1'b0}}};

  typedef enum logic {ST_FILL, ST_FLUSH} state_e;

  state_e              state_q, state_n;
  logic [BUF_W-1:0]    buf_q, buf_n;
  logic [RC_W-1:0]     rcnt_q, rcnt_n;
  logic [CNT_W-1:0]    bcnt_q, bcnt_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic                valid_q, valid_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [WORD_W-1:0]   data_q, data_n;
  logic [CNT_W-1:0]    blk_bits_q, blk_bits_n;
  logic                done_q, done_n;
  logic                fail_q, fail_n;

  logic                accept, load_ok, emit, end_blk;
  logic [BUF_W-1:0]    base_buf, placed;
  logic [RC_W-1:0]     base_cnt;
  logic [CNT_W-1:0]    base_bcnt;
  logic [CNT_W:0]      bsum;

  assign ready_o = (rcnt_q < RC_W'(WORD_W)) && (state_q == ST_FILL);
  assign accept  = valid_i && ready_o;
  assign load_ok = !valid_q || ready_i;

  // A sop restarts the buffer from the prefix, abandoning any open block.
  assign base_buf  = sop_i ? PREFIX_BUF : buf_q;
  assign base_cnt  = sop_i ? RC_W'(PREFIX_W) : rcnt_q;
  assign base_bcnt = sop_i ? CNT_W'(PREFIX_W) : bcnt_q;
  assign bsum      = {1'b0, base_bcnt} + (CNT_W+1)'(size_i);

  aidc_lite_bit_aligner #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE_W    (SIZE_W),
    .BUF_W     (BUF_W),
    .SH_W      (RC_W)
  ) u_aligner (
    .data   (data_i),
    .size   (size_i),
    .shift  (base_cnt),
    .placed (placed)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      buf_q      <= PREFIX_BUF;
      rcnt_q     <= RC_W'(PREFIX_W);
      bcnt_q     <= CNT_W'(PREFIX_W);
      idx_q      <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      blk_bits_q <= '0;
      done_q     <= 1'b1;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      buf_q      <= buf_n;
      rcnt_q     <= rcnt_n;
      bcnt_q     <= bcnt_n;
      idx_q      <= idx_n;
      valid_q    <= valid_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      blk_bits_q <= blk_bits_n;
      done_q     <= done_n;
      fail_q     <= fail_n;
    end
  end

  // Accept and emit are exclusive: ready_o is low whenever a word is pending.
  always_comb begin
    state_n    = state_q;
    buf_n      = buf_q;
    rcnt_n     = rcnt_q;
    bcnt_n     = bcnt_q;
    idx_n      = idx_q;
    valid_n    = load_ok ? 1'b0 : valid_q;
    addr_n     = addr_q;
    data_n     = data_q;
    blk_bits_n = blk_bits_q;
    done_n     = done_q;
    fail_n     = fail_q;
    emit       = 1'b0;
    end_blk    = 1'b0;

    if (accept) begin
      buf_n  = base_buf | placed;
      rcnt_n = base_cnt + RC_W'(size_i);
      bcnt_n = bsum[CNT_W] ? {CNT_W{1'b1}} : bsum[CNT_W-1:0];
      if (sop_i) begin
        idx_n  = '0;
        done_n = 1'b0;
        fail_n = 1'b0;
      end
      if (eop_i) state_n = ST_FLUSH;
    end else if (rcnt_q >= RC_W'(WORD_W)) begin
      if (load_ok) begin
        emit    = 1'b1;
        buf_n   = buf_q << WORD_W;
        rcnt_n  = rcnt_q - RC_W'(WORD_W);
        end_blk = (state_q == ST_FLUSH) && (rcnt_q == RC_W'(WORD_W));
      end
    end else if (state_q == ST_FLUSH) begin
      if (rcnt_q == '0) begin
        end_blk = 1'b1;
      end else if (load_ok) begin
        emit    = 1'b1;
        end_blk = 1'b1;
      end
    end

    // Words past MAX_WORDS are dropped silently; the index saturates.
    if (emit && (idx_q < IDX_W'(MAX_WORDS))) begin
      valid_n = 1'b1;
      data_n  = buf_q[BUF_W-1 -: WORD_W];
      addr_n  = ADDR_W'(idx_q);
      idx_n   = idx_q + IDX_W'(1);
    end

    if (end_blk) begin
      done_n     = 1'b1;
      fail_n     = 32'(bcnt_q) > LIMIT;
      blk_bits_n = bcnt_q;
      buf_n      = PREFIX_BUF;
      rcnt_n     = RC_W'(PREFIX_W);
      bcnt_n     = CNT_W'(PREFIX_W);
      state_n    = ST_FILL;
    end
  end

  assign valid_o    = valid_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign blk_bits_o = blk_bits_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;

endmodule

// File: tb/tb_aidc_lite_code_packer.sv
// Bench for aidc_lite_code_packer: bit-queue reference model plus directed blocks.
module tb_aidc_lite_code_packer;

  localparam int DATA_SIZE = 66;
  localparam int SIZE_W    = 7;
  localparam int WORD_W    = 64;
  localparam int MAX_WORDS = 8;
  localparam int ADDR_W    = 3;
  localparam int CNT_W     = 12;
  localparam int PREFIX_W  = 2;
  localparam logic [PREFIX_W-1:0] PREFIX = 2'b00;
  localparam int TMO = 200;

  logic                 clk = 1'b0;
  logic                 rst_n, valid_i, ready_o, sop_i, eop_i;
  logic [DATA_SIZE-1:0] data_i;
  logic [SIZE_W-1:0]    size_i;
  logic                 valid_o, ready_i;
  logic [ADDR_W-1:0]    addr_o;
  logic [WORD_W-1:0]    data_o;
  logic [CNT_W-1:0]     blk_bits_o;
  logic                 done_o, fail_o;

  aidc_lite_code_packer #(
    .PREFIX_W(PREFIX_W), .PREFIX(PREFIX), .DATA_SIZE(DATA_SIZE), .SIZE_W(SIZE_W),
    .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .sop_i(sop_i), .eop_i(eop_i), .data_i(data_i), .size_i(size_i),
    .valid_o(valid_o), .ready_i(ready_i), .addr_o(addr_o), .data_o(data_o),
    .blk_bits_o(blk_bits_o), .done_o(done_o), .fail_o(fail_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the block as a plain queue of bits.
  bit                mbits[$];
  int                m_total;
  int                m_idx;
  logic [WORD_W-1:0] exp_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int                exp_bits;
  bit                exp_fail;

  logic [WORD_W-1:0] got_data[$];
  logic [ADDR_W-1:0] got_addr[$];
  bit                mon_en = 1'b0;
  bit                hold_prev = 1'b0;
  logic [WORD_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;
  bit                rdy_low_seen;

  localparam logic [DATA_SIZE-1:0] ONES = '1;
  localparam logic [DATA_SIZE-1:0] D6   = {6'b101101, 60'h0};

  function automatic void check(string name, logic [WORD_W-1:0] act, logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model_start();
    logic [PREFIX_W-1:0] p = PREFIX;
    mbits.delete();
    for (int i = PREFIX_W - 1; i >= 0; i--) mbits.push_back(p[i]);
    m_total = PREFIX_W;
  endfunction

  function automatic void model_word();
    logic [WORD_W-1:0] w = '0;
    for (int i = WORD_W - 1; i >= 0; i--)
      if (mbits.size() > 0) w[i] = mbits.pop_front();
    if (m_idx < MAX_WORDS) begin
      exp_data.push_back(w);
      exp_addr.push_back(ADDR_W'(m_idx));
      m_idx++;
    end
  endfunction

  function automatic void model_accept(bit s, bit e, logic [DATA_SIZE-1:0] d, int sz);
    if (s) begin
      model_start();
      m_idx = 0;
    end
    for (int i = 0; i < sz; i++) mbits.push_back(d[DATA_SIZE-1-i]);
    m_total += sz;
    while (mbits.size() >= WORD_W) model_word();
    if (e) begin
      if (mbits.size() > 0) model_word();
      exp_bits = (m_total > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_total;
      exp_fail = m_total > MAX_WORDS * WORD_W;
      model_start();
    end
  endfunction

  // Output monitor: every handshake against the model, plus hold-stability.
  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n) begin
      if (!ready_o) rdy_low_seen = 1'b1;
      if (hold_prev) begin
        check("hold_valid", 64'(valid_o), 64'd1);
        check("hold_data", data_o, prev_data);
        check("hold_addr", 64'(addr_o), 64'(prev_addr));
      end
      if (valid_o && ready_i) begin
        got_data.push_back(data_o);
        got_addr.push_back(addr_o);
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data 0x%0h addr %0d, expected no word", data_o, addr_o);
        end else begin
          check("word_data", data_o, exp_data.pop_front());
          check("word_addr", 64'(addr_o), 64'(exp_addr.pop_front()));
        end
      end
      hold_prev = valid_o && !ready_i;
      prev_data = data_o;
      prev_addr = addr_o;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic send(input bit s, input bit e, input logic [DATA_SIZE-1:0] d, input int sz);
    int t = 0;
    @(negedge clk);
    valid_i = 1'b1; sop_i = s; eop_i = e; data_i = d; size_i = SIZE_W'(sz);
    while (!ready_o && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles, expected 1", TMO);
      valid_i = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(s, e, d, sz);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0; size_i = '0;
  endtask

  task automatic wait_block(input string name);
    int t = 0;
    idle();
    #1;
    while (!(done_o && !valid_o && exp_data.size() == 0) && t < TMO) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= TMO) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: block did not complete in %0d cycles", name, TMO);
    end
    check({name, "_done"}, 64'(done_o), 64'd1);
    check({name, "_blk_bits"}, 64'(blk_bits_o), 64'(exp_bits));
    check({name, "_fail"}, 64'(fail_o), 64'(exp_fail));
  endtask

  task automatic new_test();
    got_data.delete();
    got_addr.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_SIZE-1:0] dk;
    rst_n = 1'b0; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    data_i = '0; size_i = '0; ready_i = 1'b1;
    model_start();
    m_idx = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_addr", 64'(addr_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_blk_bits", 64'(blk_bits_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd1);
    check("rst_fail", 64'(fail_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    mon_en = 1'b1;

    // Single 6-bit fragment block
    new_test();
    send(1'b1, 1'b1, D6, 6);
    wait_block("t1");
    check("t1_words", 64'(got_data.size()), 64'd1);
    if (got_data.size() > 0) begin
      check("t1_word0", got_data[0], 64'h2D00_0000_0000_0000);
      check("t1_addr0", 64'(got_addr[0]), 64'd0);
    end
    check("t1_bits_lit", 64'(blk_bits_o), 64'd8);

    // 6+34*4 bits -> 144 bits, three words
    new_test();
    send(1'b1, 1'b0, ONES, 6);
    for (int k = 0; k < 4; k++) send(1'b0, k == 3, ONES, 34);
    wait_block("t2");
    check("t2_words", 64'(got_data.size()), 64'd3);
    if (got_data.size() == 3) begin
      check("t2_word0", got_data[0], 64'h3FFF_FFFF_FFFF_FFFF);
      check("t2_word2", got_data[2], 64'hFFFF_0000_0000_0000);
      check("t2_addr2", 64'(got_addr[2]), 64'd2);
    end
    check("t2_bits_lit", 64'(blk_bits_o), 64'd144);

    // Exactly one full word, no pad word
    new_test();
    send(1'b1, 1'b1, ONES, 62);
    wait_block("t3");
    check("t3_words", 64'(got_data.size()), 64'd1);
    if (got_data.size() > 0) check("t3_word0", got_data[0], 64'h3FFF_FFFF_FFFF_FFFF);
    check("t3_bits_lit", 64'(blk_bits_o), 64'd64);

    // Overflow: 546 bits, ninth word suppressed
    new_test();
    for (int k = 0; k < 16; k++) send(k == 0, k == 15, ONES, 34);
    wait_block("t4");
    check("t4_words", 64'(got_data.size()), 64'd8);
    if (got_data.size() == 8) check("t4_addr7", 64'(got_addr[7]), 64'd7);
    check("t4_bits_lit", 64'(blk_bits_o), 64'd546);
    check("t4_fail_lit", 64'(fail_o), 64'd1);

    // Backpressure with size-40 fragments carrying junk below the used bits
    new_test();
    rdy_low_seen = 1'b0;
    fork
      for (int k = 0; k < 6; k++) begin
        dk = {32'hA5C3_0F96 + 32'(k * 7), 34'h1_2345_6789};
        send(k == 0, k == 5, dk, 40);
      end
      begin
        repeat (4) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    wait_block("t5");
    check("t5_words", 64'(got_data.size()), 64'd4);
    check("t5_ready_dropped", 64'(rdy_low_seen), 64'd1);
    check("t5_bits_lit", 64'(blk_bits_o), 64'd242);

    // Open block abandoned by a new sop
    new_test();
    send(1'b1, 1'b0, ONES, 40);
    send(1'b1, 1'b1, D6, 6);
    wait_block("t6");
    check("t6_words", 64'(got_data.size()), 64'd1);
    if (got_data.size() > 0) check("t6_word0", got_data[0], 64'h2D00_0000_0000_0000);

    // Zero-size eop on its own block: prefix-only padded word
    new_test();
    send(1'b1, 1'b1, ONES, 0);
    wait_block("t7");
    check("t7_words", 64'(got_data.size()), 64'd1);
    if (got_data.size() > 0) check("t7_word0", got_data[0], 64'h0);
    check("t7_bits_lit", 64'(blk_bits_o), 64'd2);

    // Zero-size eop after an exact word: no pad word
    new_test();
    send(1'b1, 1'b0, ONES, 62);
    send(1'b0, 1'b1, ONES, 0);
    wait_block("t8");
    check("t8_words", 64'(got_data.size()), 64'd1);
    check("t8_bits_lit", 64'(blk_bits_o), 64'd64);

    // Reset mid-block, then a fresh block
    new_test();
    send(1'b1, 1'b0, ONES, 50);
    idle();
    @(posedge clk);
    #1 rst_n = 1'b0;
    mon_en = 1'b0;
    exp_data.delete();
    exp_addr.delete();
    model_start();
    m_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t9_rst_done", 64'(done_o), 64'd1);
    check("t9_rst_valid", 64'(valid_o), 64'd0);
    mon_en = 1'b1;
    send(1'b1, 1'b1, D6, 6);
    wait_block("t9");
    check("t9_words", 64'(got_data.size()), 64'd1);
    if (got_data.size() > 0) check("t9_word0", got_data[0], 64'h2D00_0000_0000_0000);

    check("leftover_expected", 64'(exp_data.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
